// File: rtl/legv8_multicycle_sequencer.sv
// legv8_multicycle_sequencer: multicycle LEGv8 control FSM with req/ready memory handshakes and timeout trapping.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module legv8_multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [5:0]       cls,
    input  logic             is_cbnz,
    input  logic             alu_zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cls_q, cls_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             retire;
    logic             wait_low;
    logic             fetch_go;
    logic             legal;
    logic             taken;
    logic             timed_out;

`ifdef SEQ_SINGLE_STEP_EN
    logic issued_q, issued_d;
    // step only matters until the fetch request has gone out
    assign fetch_go = issued_q | step;
    assign issued_d = (state_q == FETCH) && (state_d == FETCH) && fetch_go;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) issued_q <= 1'b0;
        else          issued_q <= issued_d;
    end
`else
    assign fetch_go = 1'b1;
`endif

    assign legal     = (cls != 6'd0) && ((cls & (cls - 6'd1)) == 6'd0);
    assign taken     = alu_zero ^ is_cbnz;
    assign timed_out = cnt_q >= 8'(MEM_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        wait_low   = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (fetch_go) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else if (timed_out) begin
                        state_d = TRAP;
                        cause_d = 2'd2;
                    end else begin
                        wait_low = 1'b1;
                    end
                end
            end
            DECODE: begin
                cls_d = cls;
                if (!legal) begin
                    state_d = TRAP;
                    cause_d = 2'd1;
                end else if (cls[5]) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cls_q[4]) begin
                    pc_write = taken;
                    pc_src   = taken;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = (cls_q[2] | cls_q[3]) ? MEM : WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls_q[3];
                if (dmem_ready) begin
                    retire  = cls_q[3];
                    state_d = cls_q[3] ? FETCH : WB;
                end else if (timed_out) begin
                    state_d = TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_low = 1'b1;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = cls_q[2];
                retire     = 1'b1;
                state_d    = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
        // every entry into FETCH or MEM is a state change, so this clears the counter there
        cnt_d = (state_d != state_q) ? 8'd0 : (wait_low ? cnt_q + 8'd1 : cnt_q);
        ret_d = ret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cls_q   <= 6'd0;
            cnt_q   <= 8'd0;
            cause_q <= 2'd0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            ret_q   <= ret_d;
        end
    end

    assign state      = state_q;
    assign trap       = (state_q == TRAP);
    assign trap_cause = cause_q;
    assign retired    = ret_q;
endmodule

// File: tb/tb_legv8_multicycle_sequencer.sv
// tb_legv8_multicycle_sequencer: per-cycle trace model of the sequencer built from instruction-level rules.
module tb_legv8_multicycle_sequencer;
    localparam int TO    = 15;
    localparam int CNT_W = 5;

    typedef struct {
        logic [2:0] st;
        logic [8:0] o;
        bit         ret;
        logic       ir;
        logic       dr;
        logic [5:0] c;
        logic       cb;
        logic       z;
        logic [1:0] tc;
    } cyc_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [5:0]       cls = 6'd0;
    logic             is_cbnz = 1'b0;
    logic             alu_zero = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
    logic             reg_write, mem_to_reg, trap;
    logic [2:0]       state;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;
    logic [8:0]       outs;

    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;
    int   cyc = 0;
    cyc_t q[$];

    legv8_multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef SEQ_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .cls(cls),
        .is_cbnz(is_cbnz),
        .alu_zero(alu_zero),
        .imem_req(imem_req),
        .imem_ready(imem_ready),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_ready(dmem_ready),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .pc_src(pc_src),
        .reg_write(reg_write),
        .mem_to_reg(mem_to_reg),
        .state(state),
        .trap(trap),
        .trap_cause(trap_cause),
        .retired(retired)
    );

    always #5 clk = ~clk;

    assign outs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg, trap};

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rc();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic void add(input logic [2:0] st, input logic [8:0] o, input bit ret, input logic ir,
                                input logic dr, input logic [5:0] c, input logic cb, input logic z,
                                input logic [1:0] tc);
        cyc_t e;
        e.st = st; e.o = o; e.ret = ret; e.ir = ir; e.dr = dr;
        e.c = c; e.cb = cb; e.z = z; e.tc = tc;
        q.push_back(e);
    endfunction

    // expected cycles for one instruction; a wait beyond TO produces only the timed-out wait cycles
    function automatic void push_instr(input logic [5:0] c, input int iw, input int dw, input logic cb, input logic z);
        logic b, t, s;
        for (int i = 0; i < ((iw > TO) ? TO + 1 : iw); i++)
            add(3'd1, {1'b1, 8'b0}, 0, 1'b0, rb(), rc(), rb(), rb(), 2'd0);
        if (iw > TO) return;
        add(3'd1, {1'b1, 2'b0, 1'b1, 1'b1, 4'b0}, 0, 1'b1, rb(), rc(), rb(), rb(), 2'd0);
        if ($countones(c) != 1) begin
            add(3'd2, 9'd0, 0, rb(), rb(), c, rb(), rb(), 2'd0);
            return;
        end
        b = c[5];
        add(3'd2, {4'b0, b, b, 3'b0}, b, rb(), rb(), c, rb(), rb(), 2'd0);
        if (b) return;
        if (c[4]) begin
            t = z ^ cb;
            add(3'd3, {4'b0, t, t, 3'b0}, 1, rb(), rb(), rc(), cb, z, 2'd0);
            return;
        end
        add(3'd3, 9'd0, 0, rb(), rb(), rc(), rb(), rb(), 2'd0);
        if (c[2] | c[3]) begin
            s = c[3];
            for (int i = 0; i < ((dw > TO) ? TO + 1 : dw); i++)
                add(3'd4, {1'b0, 1'b1, s, 6'b0}, 0, rb(), 1'b0, rc(), rb(), rb(), 2'd0);
            if (dw > TO) return;
            add(3'd4, {1'b0, 1'b1, s, 6'b0}, s, rb(), 1'b1, rc(), rb(), rb(), 2'd0);
            if (s) return;
        end
        add(3'd5, {6'b0, 1'b1, c[2], 1'b0}, 1, rb(), rb(), rc(), rb(), rb(), 2'd0);
    endfunction

    function automatic void push_trap(input int n, input logic [1:0] tc);
        for (int i = 0; i < n; i++)
            add(3'd7, 9'd1, 0, rb(), rb(), rc(), rb(), rb(), tc);
    endfunction

    task automatic run_q(input int n);
        cyc_t e;
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            e = q.pop_front();
            k++;
            @(negedge clk);
            cls = e.c; is_cbnz = e.cb; alu_zero = e.z; imem_ready = e.ir; dmem_ready = e.dr;
            #1;
            cyc++;
            checks += 4;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, e.st);
            end
            if (outs !== e.o) begin
                errors++;
                $display("FAIL outputs cyc=%0d st=%0d got=%b exp=%b", cyc, e.st, outs, e.o);
            end
            if (trap_cause !== e.tc) begin
                errors++;
                $display("FAIL trap_cause cyc=%0d got=%0d exp=%0d", cyc, trap_cause, e.tc);
            end
            if (retired !== CNT_W'(exp_ret)) begin
                errors++;
                $display("FAIL retired cyc=%0d got=%0d exp=%0d", cyc, retired, CNT_W'(exp_ret));
            end
            if (e.ret) exp_ret++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        if (outs !== 9'd0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", outs); end
        if (trap_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got=%0d exp=0", trap_cause); end
        if (retired !== '0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        exp_ret = 0;
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", state); end
    endtask

    task automatic test_r_type();
        test_reset();
        push_instr(6'b000001, 0, 0, 1'b0, 1'b0);
        push_instr(6'b000010, 0, 0, 1'b0, 1'b0);
        run_q(-1);
        @(negedge clk);
        #1;
        checks += 2;
        if (retired !== CNT_W'(2)) begin errors++; $display("FAIL r_type_retired got=%0d exp=2", retired); end
        if (state !== 3'd1) begin errors++; $display("FAIL r_type_refetch got=%0d exp=1", state); end
    endtask

    task automatic test_ldur_wait();
        test_reset();
        push_instr(6'b000100, 0, 3, 1'b0, 1'b0);
        push_instr(6'b001000, 1, 2, 1'b0, 1'b0);
        run_q(-1);
    endtask

    task automatic test_cbnz();
        test_reset();
        push_instr(6'b010000, 0, 0, 1'b1, 1'b0);
        push_instr(6'b010000, 0, 0, 1'b1, 1'b1);
        push_instr(6'b010000, 0, 0, 1'b0, 1'b1);
        push_instr(6'b100000, 0, 0, 1'b0, 1'b0);
        run_q(-1);
    endtask

    task automatic test_illegal();
        test_reset();
        push_instr(6'b000001, 0, 0, 1'b0, 1'b0);
        push_instr(6'b000011, 1, 0, 1'b0, 1'b0);
        push_trap(5, 2'd1);
        run_q(-1);
        test_reset();
        push_instr(6'b000000, 0, 0, 1'b0, 1'b0);
        push_trap(2, 2'd1);
        run_q(-1);
    endtask

    task automatic test_timeouts();
        test_reset();
        push_instr(6'b000001, 16, 0, 1'b0, 1'b0);
        push_trap(3, 2'd2);
        run_q(-1);
        test_reset();
        push_instr(6'b000001, 15, 0, 1'b0, 1'b0);
        push_instr(6'b000100, 0, 15, 1'b0, 1'b0);
        run_q(-1);
        test_reset();
        push_instr(6'b001000, 0, 16, 1'b0, 1'b0);
        push_trap(3, 2'd3);
        run_q(-1);
    endtask

    task automatic test_reset_mid_mem();
        test_reset();
        push_instr(6'b000100, 0, 16, 1'b0, 1'b0);
        run_q(5);
        #2;
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (dmem_req !== 1'b0) begin errors++; $display("FAIL async_dmem_req got=%b exp=0", dmem_req); end
        if (state !== 3'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", state); end
        q.delete();
    endtask

    task automatic test_random();
        logic [5:0] c;
        int iw, dw;
        test_reset();
        for (int n = 0; n < 45; n++) begin
            c = 6'd1 << $urandom_range(0, 5);
            iw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
            dw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
            push_instr(c, iw, dw, rb(), rb());
        end
        run_q(-1);
        @(negedge clk);
        #1;
        checks++;
        if (retired !== CNT_W'(exp_ret)) begin
            errors++;
            $display("FAIL random_final_retired got=%0d exp=%0d", retired, CNT_W'(exp_ret));
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_ldur_wait();
        test_cbnz();
        test_illegal();
        test_timeouts();
        test_reset_mid_mem();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
